doodlejump_led_animator: RTL and testbench



---
 rtl/doodlejump_led_animator.sv | 134 +++++++++++++
 tb/tb_doodlejump_led_animator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doodlejump_led_animator.sv
// doodlejump_led_animator: turns one 14-bit LED PIO word into animated, dimmed LED drive.
// Ports:
//   CLK      in   system clock
//   RESET    in   synchronous active-high reset
//   pio_data in   [9:0] pattern, [11:10] mode, [13:12] brightness
//   leds     out  registered LED drive after PWM
//   frame    out  current animation frame before PWM
//   tick     out  animation tick strobe (combinational from registered state)
module doodlejump_led_animator #(
    parameter int TICK_DIV = 5000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [13:0] pio_data,
    output logic [9:0]  leds,
    output logic [9:0]  frame,
    output logic        tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        M_STATIC = 2'b00,
        M_BLINK  = 2'b01,
        M_ROTATE = 2'b10,
        M_BOUNCE = 2'b11
    } mode_t;

    logic [13:0]   r_cfg;
    logic [CW-1:0] r_count;
    logic          r_phase;
    logic [3:0]    r_pos;
    logic          r_dir;
    logic [9:0]    r_frame;
    logic [1:0]    r_pwm;
    logic [9:0]    r_leds;

    logic          w_restart;
    logic          w_tick;
    logic          w_pwm_on;
    mode_t         w_mode;
    mode_t         w_mode_new;
    logic [3:0]    w_pos_nxt;
    logic          w_dir_nxt;

    // Brightness bits are excluded so dimming never restarts an animation.
    assign w_restart  = (pio_data[11:0] != r_cfg[11:0]);
    assign w_tick     = (r_count == LAST) && !w_restart;
    assign w_pwm_on   = (r_pwm <= r_cfg[13:12]);
    assign w_mode     = mode_t'(r_cfg[11:10]);
    assign w_mode_new = mode_t'(pio_data[11:10]);

    // Bounce reflects at the ends so the lit LED never sits on an end twice.
    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (r_dir == DIR_UP) begin
            if (r_pos == 4'd9) begin
                w_dir_nxt = DIR_DN;
                w_pos_nxt = 4'd8;
            end else begin
                w_pos_nxt = r_pos + 4'd1;
            end
        end else begin
            if (r_pos == 4'd0) begin
                w_dir_nxt = DIR_UP;
                w_pos_nxt = 4'd1;
            end else begin
                w_pos_nxt = r_pos - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cfg   <= '0;
            r_count <= '0;
            r_phase <= 1'b1;
            r_pos   <= '0;
            r_dir   <= DIR_UP;
            r_frame <= '0;
            r_pwm   <= '0;
            r_leds  <= '0;
        end else begin
            r_cfg  <= pio_data;
            r_pwm  <= r_pwm + 2'd1;
            r_leds <= r_frame & {10{w_pwm_on}};
            if (w_restart) begin
                r_count <= '0;
                r_phase <= 1'b1;
                r_pos   <= '0;
                r_dir   <= DIR_UP;
                if (w_mode_new == M_BOUNCE) begin
                    r_frame <= 10'h001;
                end else begin
                    r_frame <= pio_data[9:0];
                end
            end else begin
                if (r_count == LAST) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + CW'(1);
                end
                if (w_tick) begin
                    unique case (w_mode)
                        M_STATIC: begin
                            r_frame <= r_cfg[9:0];
                        end
                        M_BLINK: begin
                            r_phase <= ~r_phase;
                            r_frame <= (~r_phase) ? r_cfg[9:0] : 10'h000;
                        end
                        M_ROTATE: begin
                            r_frame <= {r_frame[8:0], r_frame[9]};
                        end
                        M_BOUNCE: begin
                            r_pos   <= w_pos_nxt;
                            r_dir   <= w_dir_nxt;
                            r_frame <= 10'h001 << w_pos_nxt;
                        end
                    endcase
                end
            end
        end
    end

    assign leds  = r_leds;
    assign frame = r_frame;
    assign tick  = w_tick;

endmodule

// File: tb/tb_doodlejump_led_animator.sv
// tb_doodlejump_led_animator: directed self-checking bench for doodlejump_led_animator.
// Two instances share stimulus: TICK_DIV=4 (most scenarios) and TICK_DIV=2 (bounce).
module tb_doodlejump_led_animator;

    logic        clk;
    logic        rst;
    logic [13:0] pio;
    logic [9:0]  leds4, frame4, leds2, frame2;
    logic        tick4, tick2;

    int n_cmp = 0;
    int n_err = 0;

    doodlejump_led_animator #(.TICK_DIV(4)) dut4 (
        .CLK(clk), .RESET(rst), .pio_data(pio),
        .leds(leds4), .frame(frame4), .tick(tick4)
    );

    doodlejump_led_animator #(.TICK_DIV(2)) dut2 (
        .CLK(clk), .RESET(rst), .pio_data(pio),
        .leds(leds2), .frame(frame2), .tick(tick2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] v);
        return {v[8:0], v[9]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        pio = 14'h3FFF;
        step();
        step();
        n_cmp++;
        if (frame4 !== 10'h000) begin
            n_err++;
            $display("FAIL reset_frame got=%h exp=%h", frame4, 10'h000);
        end
        n_cmp++;
        if (leds4 !== 10'h000) begin
            n_err++;
            $display("FAIL reset_leds got=%h exp=%h", leds4, 10'h000);
        end
        pio = 14'h0000;
        #1;
        n_cmp++;
        if (tick4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tick got=%b exp=0", tick4);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (frame4 !== 10'h000 || leds4 !== 10'h000) begin
            n_err++;
            $display("FAIL reset_idle got=%h/%h exp=000/000", frame4, leds4);
        end
    endtask

    task automatic test_static();
        int nt;
        pio = 14'h32A5;
        step();
        n_cmp++;
        if (frame4 !== 10'h2A5) begin
            n_err++;
            $display("FAIL static_edge1_frame got=%h exp=2a5", frame4);
        end
        n_cmp++;
        if (leds4 !== 10'h000) begin
            n_err++;
            $display("FAIL static_edge1_leds got=%h exp=000", leds4);
        end
        step();
        n_cmp++;
        if (leds4 !== 10'h2A5) begin
            n_err++;
            $display("FAIL static_edge2_leds got=%h exp=2a5", leds4);
        end
        nt = 0;
        for (int k = 2; k <= 13; k++) begin
            if (k > 2) step();
            if (tick4 === 1'b1) nt++;
            n_cmp++;
            if (frame4 !== 10'h2A5 || leds4 !== 10'h2A5) begin
                n_err++;
                $display("FAIL static_hold k=%0d got=%h/%h exp=2a5", k, frame4, leds4);
            end
        end
        n_cmp++;
        if (nt != 3) begin
            n_err++;
            $display("FAIL static_tick_count got=%0d exp=3", nt);
        end
    endtask

    task automatic test_blink();
        logic [9:0] ef, ep;
        pio = 14'h34F0;
        step();
        n_cmp++;
        if (frame4 !== 10'h0F0) begin
            n_err++;
            $display("FAIL blink_start got=%h exp=0f0", frame4);
        end
        ep = 10'h0F0;
        for (int k = 1; k <= 16; k++) begin
            step();
            ef = (((k / 4) % 2) == 0) ? 10'h0F0 : 10'h000;
            n_cmp++;
            if (frame4 !== ef) begin
                n_err++;
                $display("FAIL blink_frame k=%0d got=%h exp=%h", k, frame4, ef);
            end
            n_cmp++;
            if (tick4 !== ((k % 4) == 3)) begin
                n_err++;
                $display("FAIL blink_tick k=%0d got=%b exp=%b", k, tick4, (k % 4) == 3);
            end
            if (k <= 8) begin
                n_cmp++;
                if (leds4 !== ep) begin
                    n_err++;
                    $display("FAIL blink_leds k=%0d got=%h exp=%h", k, leds4, ep);
                end
            end
            ep = ef;
            // Brightness-only write mid-blink: phase and count must carry on.
            if (k == 8) pio = 14'h14F0;
        end
    endtask

    task automatic test_rotate();
        logic [9:0] e;
        pio = 14'h3A01;
        step();
        e = 10'h201;
        n_cmp++;
        if (frame4 !== e) begin
            n_err++;
            $display("FAIL rotate_start got=%h exp=%h", frame4, e);
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            if ((k % 4) == 0) e = rotl(e);
            n_cmp++;
            if (frame4 !== e) begin
                n_err++;
                $display("FAIL rotate_frame k=%0d got=%h exp=%h", k, frame4, e);
            end
        end
        n_cmp++;
        if (frame4 !== 10'h201) begin
            n_err++;
            $display("FAIL rotate_wrap got=%h exp=201", frame4);
        end
        pio = 14'h3BFF;
        for (int k = 0; k < 9; k++) begin
            step();
            n_cmp++;
            if (frame4 !== 10'h3FF) begin
                n_err++;
                $display("FAIL rotate_allones k=%0d got=%h exp=3ff", k, frame4);
            end
        end
    endtask

    task automatic test_restart_on_tick();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (tick4 === 1'b1) found = 1'b1;
            else step();
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL coincide_wait got=no_tick exp=tick_within_10");
        end
        pio = 14'h3955;
        #1;
        n_cmp++;
        if (tick4 !== 1'b0) begin
            n_err++;
            $display("FAIL coincide_tick got=%b exp=0", tick4);
        end
        step();
        n_cmp++;
        if (frame4 !== 10'h155) begin
            n_err++;
            $display("FAIL coincide_frame got=%h exp=155", frame4);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++;
            if (tick4 !== (k == 3) || frame4 !== 10'h155) begin
                n_err++;
                $display("FAIL coincide_count k=%0d got=%b/%h exp=%b/155", k, tick4, frame4, k == 3);
            end
        end
        step();
        n_cmp++;
        if (frame4 !== 10'h2AA) begin
            n_err++;
            $display("FAIL coincide_step got=%h exp=2aa", frame4);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (frame4 !== 10'h000 || leds4 !== 10'h000 || tick4 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset got=%h/%h/%b exp=000/000/0", frame4, leds4, tick4);
        end
        rst = 1'b0;
    endtask

    task automatic test_bounce();
        int n, p;
        logic [9:0] e;
        pio = 14'h3C00;
        step();
        n_cmp++;
        if (frame2 !== 10'h001) begin
            n_err++;
            $display("FAIL bounce_start got=%h exp=001", frame2);
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            n = k / 2;
            p = ((n % 18) < 10) ? (n % 18) : (18 - (n % 18));
            e = 10'h001 << p;
            n_cmp++;
            if (frame2 !== e) begin
                n_err++;
                $display("FAIL bounce_frame k=%0d got=%h exp=%h", k, frame2, e);
            end
            n_cmp++;
            if (tick2 !== ((k % 2) == 1)) begin
                n_err++;
                $display("FAIL bounce_tick k=%0d got=%b exp=%b", k, tick2, (k % 2) == 1);
            end
        end
    endtask

    task automatic test_brightness();
        int on;
        logic [1:0] bb;
        for (int b = 0; b < 4; b++) begin
            bb = 2'(b);
            pio = {bb, 2'b00, 10'h3FF};
            for (int k = 0; k < 4; k++) step();
            on = 0;
            for (int k = 0; k < 4; k++) begin
                step();
                if (leds4 === 10'h3FF) on++;
                n_cmp++;
                if (leds4 !== 10'h3FF && leds4 !== 10'h000) begin
                    n_err++;
                    $display("FAIL pwm_level b=%0d got=%h exp=000_or_3ff", b, leds4);
                end
            end
            n_cmp++;
            if (on != b + 1) begin
                n_err++;
                $display("FAIL pwm_duty b=%0d got=%0d exp=%0d", b, on, b + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pio = '0;
        test_reset();
        test_static();
        test_blink();
        test_rotate();
        test_restart_on_tick();
        test_bounce();
        test_brightness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
